// File: rtl/ram2_ctrl.sv
// Arbiter/timing controller sharing the single-ported RAM2 SRAM between
// instruction fetch and MEM-stage data accesses.
module ram2_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter logic [DATA_W-1:0] NOP_INST = 16'h0800
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      pc,
    output logic [DATA_W-1:0]      inst,
    output logic                   inst_valid,
    input  logic                   mem_ce,
    input  logic                   mem_re,
    input  logic                   mem_we,
    input  logic [ADDR_W-1:0]      mem_addr_i,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic [DATA_W-1:0]      mem_data_o,
    output logic                   mem_done,
    output logic                   stall_req,
    output logic [SRAM_ADDR_W-1:0] ram2_addr,
    output logic [DATA_W-1:0]      ram2_data_o,
    input  logic [DATA_W-1:0]      ram2_data_i,
    output logic                   ram2_data_oe,
    output logic                   ram2_en_n,
    output logic                   ram2_oe_n,
    output logic                   ram2_we_n
);

    // state    | meaning
    // FETCH    | instruction fetch at pc, watching for MEM requests
    // MEM_RD   | data read from latched address
    // WR_SETUP | address/data driven, we_n still high
    // WR_PULSE | we_n low
    // WR_HOLD  | we_n back high, address/data held
    // DONE     | completion pulse, normal fetch at pc
    typedef enum logic [2:0] {
        FETCH, MEM_RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE
    } state_t;

    localparam int PAD_W = SRAM_ADDR_W - ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              req;

    assign req = mem_ce & (mem_re | mem_we);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            mem_data_o <= '0;
            mem_done   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                FETCH: begin
                    if (req) begin
                        inst       <= NOP_INST;
                        inst_valid <= 1'b0;
                        addr_q     <= mem_addr_i;
                        data_q     <= mem_data_i;
                        // write wins when both re and we are asserted
                        state      <= mem_we ? WR_SETUP : MEM_RD;
                    end else begin
                        inst       <= ram2_data_i;
                        inst_valid <= 1'b1;
                    end
                end
                MEM_RD: begin
                    mem_data_o <= ram2_data_i;
                    mem_done   <= 1'b1;
                    state      <= DONE;
                end
                WR_SETUP: state <= WR_PULSE;
                WR_PULSE: state <= WR_HOLD;
                WR_HOLD: begin
                    mem_done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    inst       <= ram2_data_i;
                    inst_valid <= 1'b1;
                    state      <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        stall_req    = 1'b0;
        ram2_en_n    = 1'b1;
        ram2_oe_n    = 1'b1;
        ram2_we_n    = 1'b1;
        ram2_data_oe = 1'b0;
        ram2_addr    = '0;
        if (rst) begin
            case (state)
                FETCH, DONE: begin
                    ram2_en_n = 1'b0;
                    ram2_oe_n = 1'b0;
                    ram2_addr = {{PAD_W{1'b0}}, pc};
                    stall_req = (state == FETCH) && req;
                end
                MEM_RD: begin
                    stall_req = 1'b1;
                    ram2_en_n = 1'b0;
                    ram2_oe_n = 1'b0;
                    ram2_addr = {{PAD_W{1'b0}}, addr_q};
                end
                WR_SETUP, WR_PULSE, WR_HOLD: begin
                    stall_req    = 1'b1;
                    ram2_en_n    = 1'b0;
                    ram2_data_oe = 1'b1;
                    ram2_we_n    = (state != WR_PULSE);
                    ram2_addr    = {{PAD_W{1'b0}}, addr_q};
                end
                default: ;
            endcase
        end
    end

    assign ram2_data_o = data_q;

endmodule

// File: tb/tb_ram2_ctrl.sv
// Self-checking bench for ram2_ctrl: SRAM model on the pins plus a
// transaction-level reference of memory contents and per-cycle timing.
module tb_ram2_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] inst;
    logic        inst_valid;
    logic        mem_ce, mem_re, mem_we;
    logic [15:0] mem_addr_i, mem_data_i, mem_data_o;
    logic        mem_done, stall_req;
    logic [17:0] ram2_addr;
    logic [15:0] ram2_data_o, ram2_data_i;
    logic        ram2_data_oe, ram2_en_n, ram2_oe_n, ram2_we_n;

    int n_cmp = 0;
    int n_bad = 0;
    bit excl_on = 1'b0;

    logic [15:0] sram    [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] exp_inst;
    logic        exp_valid;
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    ram2_ctrl dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .inst_valid(inst_valid),
        .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o), .mem_done(mem_done), .stall_req(stall_req),
        .ram2_addr(ram2_addr), .ram2_data_o(ram2_data_o), .ram2_data_i(ram2_data_i),
        .ram2_data_oe(ram2_data_oe), .ram2_en_n(ram2_en_n),
        .ram2_oe_n(ram2_oe_n), .ram2_we_n(ram2_we_n)
    );

    // asynchronous SRAM model driven purely by the pins
    assign ram2_data_i = (!ram2_en_n && !ram2_oe_n) ? sram[ram2_addr[15:0]] : 16'hDEAD;

    always @(posedge clk)
        if (!ram2_en_n && !ram2_we_n && ram2_data_oe)
            sram[ram2_addr[15:0]] <= ram2_data_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (excl_on) chk("oe_we_excl", {31'd0, ram2_oe_n | ram2_we_n}, 32'd1);

    function automatic logic [3:0] pins();
        return {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data_oe};
    endfunction

    task automatic chk_inst();
        chk("inst", {16'd0, inst}, {16'd0, exp_inst});
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_valid});
    endtask

    task automatic fetch_op(input logic [15:0] p);
        @(posedge clk); #1;
        pc = p; mem_ce = 1'b0; mem_re = 1'($urandom); mem_we = 1'($urandom);
        @(negedge clk);
        chk_inst();
        chk("f_stall", {31'd0, stall_req}, 32'd0);
        chk("f_pins", {28'd0, pins()}, 32'h2);
        chk("f_addr", {14'd0, ram2_addr}, {16'd0, p});
        chk("f_done", {31'd0, mem_done}, 32'd0);
        exp_inst = ref_mem[p]; exp_valid = 1'b1;
    endtask

    task automatic mem_op(input bit wr, input bit both, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] p);
        @(posedge clk); #1;
        pc = p; mem_ce = 1'b1; mem_re = !wr || both; mem_we = wr;
        mem_addr_i = a; mem_data_i = d;
        @(negedge clk);
        chk_inst();
        chk("t0_stall", {31'd0, stall_req}, 32'd1);
        chk("t0_pins", {28'd0, pins()}, 32'h2);
        chk("t0_addr", {14'd0, ram2_addr}, {16'd0, p});
        exp_inst = NOP; exp_valid = 1'b0;
        if (!wr) begin
            @(negedge clk);
            chk_inst();
            chk("rd_t1_stall", {31'd0, stall_req}, 32'd1);
            chk("rd_t1_pins", {28'd0, pins()}, 32'h2);
            chk("rd_t1_addr", {14'd0, ram2_addr}, {16'd0, a});
            chk("rd_t1_done", {31'd0, mem_done}, 32'd0);
            last_rd = ref_mem[a];
        end else begin
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                chk_inst();
                chk("wr_stall", {31'd0, stall_req}, 32'd1);
                chk("wr_pins", {28'd0, pins()}, (k == 2) ? 32'h5 : 32'h7);
                chk("wr_addr", {14'd0, ram2_addr}, {16'd0, a});
                chk("wr_data", {16'd0, ram2_data_o}, {16'd0, d});
                chk("wr_done", {31'd0, mem_done}, 32'd0);
            end
            ref_mem[a] = d;
        end
        @(negedge clk);
        chk_inst();
        chk("done_pulse", {31'd0, mem_done}, 32'd1);
        chk("done_rdata", {16'd0, mem_data_o}, {16'd0, last_rd});
        chk("done_stall", {31'd0, stall_req}, 32'd0);
        chk("done_pins", {28'd0, pins()}, 32'h2);
        chk("done_addr", {14'd0, ram2_addr}, {16'd0, p});
        exp_inst = ref_mem[p]; exp_valid = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'($urandom);
        ref_mem[0] = 16'h0800; ref_mem[1] = 16'h0800; ref_mem[2] = 16'h69BF;
        ref_mem[5] = 16'h1234;
        for (int i = 0; i < 65536; i++) sram[i] = ref_mem[i];

        rst = 1'b0; pc = 16'd5; mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        mem_addr_i = '0; mem_data_i = '0;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_inst", {16'd0, inst}, {16'd0, NOP});
            chk("rst_valid", {31'd0, inst_valid}, 32'd0);
            chk("rst_pins", {28'd0, pins()}, 32'hE);
            chk("rst_stall", {31'd0, stall_req}, 32'd0);
            chk("rst_addr", {14'd0, ram2_addr}, 32'd0);
            chk("rst_done", {31'd0, mem_done}, 32'd0);
            chk("rst_rdata", {16'd0, mem_data_o}, 32'd0);
        end
        rst = 1'b1; pc = 16'd0;
        exp_inst = ref_mem[0]; exp_valid = 1'b1;
        excl_on = 1'b1;

        fetch_op(16'd0); fetch_op(16'd1); fetch_op(16'd2); fetch_op(16'd3);
        mem_op(1'b0, 1'b0, 16'h0005, 16'h0000, 16'd4);
        fetch_op(16'd4);
        mem_op(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'd6);
        mem_op(1'b1, 1'b1, 16'h0011, 16'hCAFE, 16'd7);
        mem_op(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0010);
        fetch_op(16'h0011);

        // reset during WR_PULSE; data matches current contents so either outcome is consistent
        @(posedge clk); #1;
        pc = 16'd8; mem_ce = 1'b1; mem_re = 1'b0; mem_we = 1'b1;
        mem_addr_i = 16'h0012; mem_data_i = ref_mem[16'h0012];
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_now_pins", {28'd0, pins()}, 32'hE);
        @(negedge clk);
        chk("rstw_pins", {28'd0, pins()}, 32'hE);
        chk("rstw_stall", {31'd0, stall_req}, 32'd0);
        chk("rstw_inst", {16'd0, inst}, {16'd0, NOP});
        chk("rstw_valid", {31'd0, inst_valid}, 32'd0);
        chk("rstw_done", {31'd0, mem_done}, 32'd0);
        rst = 1'b1; mem_ce = 1'b0; pc = 16'd9;
        last_rd = '0;
        exp_inst = ref_mem[9]; exp_valid = 1'b1;
        fetch_op(16'd10);

        for (int i = 0; i < 80; i++) begin
            int r;
            logic [15:0] a, d, p;
            r = $urandom_range(0, 9);
            a = 16'($urandom_range(0, 31));
            d = 16'($urandom);
            p = 16'($urandom_range(0, 31));
            if (r < 5)       fetch_op(p);
            else if (r < 7)  mem_op(1'b0, 1'b0, a, d, p);
            else if (r < 9)  mem_op(1'b1, 1'b0, a, d, p);
            else             mem_op(1'b1, 1'b1, a, d, p);
        end
        fetch_op(16'd0);
        excl_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram2_ctrl.md
Name: ram2_ctrl

Overview:
- Arbiter and timing controller between the CPU's IF and MEM stages and the single-ported RAM2 SRAM, which holds both instructions and data.
- By default it fetches one instruction per cycle at pc.
- When the MEM stage requests a RAM2 access, it raises stall_req, runs a multi-cycle SRAM read or write sequence, then resumes fetching.
- It drives the SRAM's active-low control pins and returns read data to the MEM stage.

Parameters:
- ADDR_W, 16, CPU-side address width
- DATA_W, 16, instruction/data word width
- SRAM_ADDR_W, 18, physical SRAM address width
- NOP_INST, 16'h0800, instruction word presented when no valid fetch exists

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- pc  in  ADDR_W  fetch address from IF
- inst  out  DATA_W  fetched instruction, registered
- inst_valid  out  1  inst holds a real fetch
- mem_ce  in  1  MEM stage targets RAM2
- mem_re  in  1  read request
- mem_we  in  1  write request
- mem_addr_i  in  ADDR_W  data address
- mem_data_i  in  DATA_W  write data
- mem_data_o  out  DATA_W  read data, registered
- mem_done  out  1  one-cycle completion pulse
- stall_req  out  1  freeze IF/ID/EX/MEM
- ram2_addr  out  SRAM_ADDR_W  SRAM address, {2'b00, addr}
- ram2_data_o  out  DATA_W  SRAM write data
- ram2_data_i  in  DATA_W  SRAM read data
- ram2_data_oe  out  1  enables the data bus driver (top level owns the tristate)
- ram2_en_n  out  1  chip enable, active-low
- ram2_oe_n  out  1  output enable, active-low
- ram2_we_n  out  1  write enable, active-low

Behaviour:
- States: FETCH, MEM_RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Reset: rst=0 at a clk edge forces state=FETCH, inst=NOP_INST, inst_valid=0, mem_data_o=0, mem_done=0, latched addr/data=0. While rst=0, combinational outputs are forced inactive: en_n=1, oe_n=1, we_n=1, data_oe=0, stall_req=0, ram2_addr=0. Reset in any state, including mid-write, aborts the sequence; we_n=1 and data_oe=0 from the cycle after the reset edge.
- Request detection: req = mem_ce & (mem_re | mem_we), evaluated only in FETCH. If mem_re and mem_we are both 1, the write wins and mem_data_o is unchanged.
- FETCH:
  - Drives en_n=0, oe_n=0, we_n=1, addr={2'b00,pc}.
  - If !req: inst<=ram2_data_i, inst_valid<=1 (one-cycle fetch latency).
  - If req: stall_req=1 combinationally in the same cycle; inst<=NOP_INST, inst_valid<=0; mem_addr_i and mem_data_i are latched; next state is MEM_RD (read) or WR_SETUP (write).
- MEM_RD: stall_req=1, en_n=0, oe_n=0, addr=latched. At the clock edge mem_data_o<=ram2_data_i. Next state DONE.
- WR_SETUP: stall_req=1, en_n=0, oe_n=1, we_n=1, data_oe=1, addr and data latched. Next state WR_PULSE.
- WR_PULSE: as WR_SETUP but we_n=0. Next state WR_HOLD.
- WR_HOLD: we_n=1, data_oe=1, addr and data still stable. Next state DONE.
- DONE:
  - mem_done=1, stall_req=0; performs a normal fetch at pc (inst and inst_valid update as in FETCH without req).
  - mem_ce, mem_re and mem_we are ignored this cycle because they still belong to the completed request.
  - Next state FETCH.
- Latency, T0 = request cycle:
  - Read: stall T0–T1; mem_data_o and mem_done at T2.
  - Write: stall T0–T3; we_n low only in T2; mem_done at T4.
- In all states except WR_*, data_oe=0. oe_n and we_n are never both 0.
- mem_done is 0 in every state other than DONE. mem_data_o holds its value until the next read.

Test Plan:
- Reset: hold rst=0 for 3 cycles with pc=5 -> inst=16'h0800, inst_valid=0, en_n=oe_n=we_n=1, stall_req=0.
- Fetch stream: SRAM[0..2] = 16'h0800, 16'h0800, 16'h69BF; pc=0,1,2 on consecutive cycles -> inst=16'h0800, 16'h0800, 16'h69BF one cycle after each pc, inst_valid=1 throughout.
- Read: SRAM[5]=16'h1234; mem_ce=1, mem_re=1, mem_addr_i=5 at T0 -> stall_req=1 in T0–T1, inst_valid=0 at T1, mem_data_o=16'h1234 and mem_done=1 at T2, fetch resumes at T2.
- Write: mem_ce=1, mem_we=1, addr=16'h0010, data=16'hBEEF -> data_oe=1 in T1–T3, we_n=0 only in T2, ram2_addr=18'h00010 stable over T1–T3, mem_done at T4; a later read of 16'h0010 returns 16'hBEEF.
- Conflict: mem_re=1 and mem_we=1 with mem_data_o previously 16'h1234 -> write sequence executes, mem_data_o stays 16'h1234.
- Reset mid-write: rst=0 during WR_PULSE -> next cycle we_n=1, data_oe=0, stall_req=0, state FETCH, inst=16'h0800.
